// File: rtl/prog_pkt_rx.sv
`default_nettype none
//==============================================================================
// Module   : prog_pkt_rx
// Function : Framed UART packet receiver with XOR checksum; verified payloads
//            are held in a shadow register and committed on frame_start.
// Revision : 1.0 - initial release
//==============================================================================
module prog_pkt_rx #(
    parameter int         PROG_PAYLD_PKT_BITS = 48,
    parameter logic [7:0] SYNC_BYTE           = 8'hA5,
    parameter int         TIMEOUT_CYCLES      = 1000000
) (
    input  logic                           clk_pix,
    input  logic                           rst_pix,
    input  logic                           rx_valid,
    input  logic [7:0]                     rx_data,
    input  logic                           frame_start,
    output logic [PROG_PAYLD_PKT_BITS-1:0] prog_buffer,
    output logic                           is_sym_mode,
    output logic                           pkt_ok,
    output logic                           pkt_err,
    output logic                           busy
);

    localparam int c_payld_bytes = PROG_PAYLD_PKT_BITS / 8;
    localparam int c_idx_w       = (c_payld_bytes > 1) ? $clog2(c_payld_bytes) : 1;
    localparam int c_tmo_w       = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(c_payld_bytes - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         c_cmd_prog = 8'h01;
    localparam logic [7:0]         c_cmd_exit = 8'h02;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CMD     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CHECK   = 2'd3
    } state_t;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [c_idx_w-1:0]               r_idx;
    logic [c_idx_w-1:0]               w_idx_nxt;
    logic [7:0]                       r_chk;
    logic [7:0]                       w_chk_nxt;
    logic                             r_kind_prog;
    logic                             w_kind_nxt;
    logic [c_tmo_w-1:0]               r_tmo;
    logic [PROG_PAYLD_PKT_BITS-1:0]   r_asm;
    logic [PROG_PAYLD_PKT_BITS-1:0]   r_shadow;
    logic                             r_pend;
    logic                             r_pend_prog;
    logic [PROG_PAYLD_PKT_BITS-1:0]   r_prog_buffer;
    logic                             r_sym_mode;
    logic                             r_pkt_ok;
    logic                             r_pkt_err;
    logic                             w_asm_wr;
    logic                             w_accept;
    logic                             w_reject;
    logic                             w_timeout;
    logic                             w_commit;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_chk       <= '0;
            r_kind_prog <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_chk       <= w_chk_nxt;
            r_kind_prog <= w_kind_nxt;
        end
    end

    // A byte arriving on the timeout cycle keeps the packet alive.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_chk_nxt   = r_chk;
        w_kind_nxt  = r_kind_prog;
        w_asm_wr    = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_timeout   = (r_state != S_IDLE) && !rx_valid && (r_tmo == c_tmo_last);
        case (r_state)
            S_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                if (rx_valid) begin
                    if (rx_data == c_cmd_prog) begin
                        w_state_nxt = S_PAYLOAD;
                        w_idx_nxt   = '0;
                        w_chk_nxt   = c_cmd_prog;
                        w_kind_nxt  = 1'b1;
                    end else if (rx_data == c_cmd_exit) begin
                        w_state_nxt = S_CHECK;
                        w_chk_nxt   = c_cmd_exit;
                        w_kind_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_reject    = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    w_asm_wr  = 1'b1;
                    w_chk_nxt = r_chk ^ rx_data;
                    if (r_idx == c_idx_last) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_idx_nxt = r_idx + c_idx_w'(1);
                    end
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    w_state_nxt = S_IDLE;
                    if (rx_data == r_chk) begin
                        w_accept = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_reject    = 1'b1;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_tmo <= '0;
        end else if (rx_valid || (r_state == S_IDLE) || w_timeout) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + c_tmo_w'(1);
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_asm <= '0;
        end else if (w_asm_wr) begin
            for (int b = 0; b < c_payld_bytes; b++) begin
                if (r_idx == c_idx_w'(b)) begin
                    r_asm[b*8 +: 8] <= rx_data;
                end
            end
        end
    end

    // Commit sees the pending state from before this cycle, so a packet
    // accepted alongside frame_start waits for the next frame.
    assign w_commit = frame_start && r_pend;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_shadow      <= '0;
            r_pend        <= 1'b0;
            r_pend_prog   <= 1'b0;
            r_prog_buffer <= '0;
            r_sym_mode    <= 1'b0;
            r_pkt_ok      <= 1'b0;
            r_pkt_err     <= 1'b0;
        end else begin
            r_pkt_ok  <= w_accept;
            r_pkt_err <= w_reject;
            if (w_commit) begin
                if (r_pend_prog) begin
                    r_prog_buffer <= r_shadow;
                    r_sym_mode    <= 1'b1;
                end else begin
                    r_sym_mode    <= 1'b0;
                end
            end
            if (w_accept) begin
                r_pend      <= 1'b1;
                r_pend_prog <= r_kind_prog;
                if (r_kind_prog) begin
                    r_shadow <= r_asm;
                end
            end else if (w_commit) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign prog_buffer = r_prog_buffer;
    assign is_sym_mode = r_sym_mode;
    assign pkt_ok      = r_pkt_ok;
    assign pkt_err     = r_pkt_err;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/prog_pkt_rx.md
Name: prog_pkt_rx

Overview:
- Byte-stream receiver and packet assembler that produces the `prog_buffer` and `is_sym_mode` inputs consumed by the render stage.
- Parses framed command packets from the UART byte interface and verifies an XOR checksum.
- Holds each verified payload in a shadow register; it reaches the render stage only at a frame boundary, so a rectangle never tears mid-frame.

Parameters:
- PROG_PAYLD_PKT_BITS, 48, payload width in bits; must be a multiple of 8 and ≥ 8; PAYLD_BYTES = PROG_PAYLD_PKT_BITS/8.
- SYNC_BYTE, 8'hA5, packet start marker.
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a packet before abort; ≥ 2.

Ports:
- clk_pix  in  1  pixel clock; sole clock.
- rst_pix  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- frame_start  in  1  one-cycle pulse at the first pixel of each frame.
- prog_buffer  out  PROG_PAYLD_PKT_BITS  committed payload to render. Bits [15:0] height, [31:16] width, [35:32] R, [39:36] G, [43:40] B.
- is_sym_mode  out  1  committed symbol-mode flag.
- pkt_ok  out  1  one-cycle pulse: packet accepted into shadow.
- pkt_err  out  1  one-cycle pulse: packet rejected (bad cmd, bad checksum, timeout).
- busy  out  1  high while state ≠ IDLE.

Behaviour:
- Reset (async assert, sync release): prog_buffer=0, is_sym_mode=0, pkt_ok=0, pkt_err=0, busy=0, state=IDLE, shadow=0, pending=0, timeout counter=0.
- Packet format:
  - SYNC_BYTE, then CMD, then payload (PROG only), then CHK.
  - CMD 8'h01 = PROG, followed by PAYLD_BYTES bytes, little-endian (first byte → bits [7:0]).
  - CMD 8'h02 = EXIT, no payload.
  - CHK = XOR of CMD and all payload bytes.
- State machine (advances only on rx_valid unless noted):
  - IDLE: byte == SYNC_BYTE → CMD; any other byte is discarded silently.
  - CMD: 01 → PAYLOAD (byte index 0, chk=01); 02 → CHECK (chk=02); other → pkt_err, IDLE.
  - PAYLOAD: write byte into assembly register at the index, chk ^= byte. At index PAYLD_BYTES-1 go to CHECK, otherwise index+1. SYNC_BYTE inside the payload is ordinary data.
  - CHECK: byte == chk → copy assembly to shadow (PROG only), set pending with kind=PROG/EXIT, pulse pkt_ok, IDLE. Otherwise → pkt_err, IDLE; shadow and pending unchanged.
- Timeout:
  - Counter clears on every rx_valid and in IDLE; increments otherwise.
  - Reaching TIMEOUT_CYCLES in any non-IDLE state → pkt_err, IDLE.
  - rx_valid in the same cycle as the timeout wins (byte processed, no error).
- pkt_ok and pkt_err are asserted in the cycle after the deciding byte/timeout, for exactly one cycle, and are never both high.
- Commit, on a cycle with frame_start=1 and pending=1:
  - PROG: prog_buffer ← shadow, is_sym_mode ← 1.
  - EXIT: is_sym_mode ← 0, prog_buffer retained.
  - pending clears in the same cycle.
- Outputs change only at commit; latency is from the first frame_start after pkt_ok.
- Simultaneous events:
  - A packet completing in the same cycle as frame_start is not committed by that frame_start; it commits at the next one.
  - A second accepted packet while pending=1 overwrites shadow and kind; the last packet wins.
- A rejected packet never disturbs a pending or committed value.
- Mid-operation reset returns everything to reset values immediately; the partial packet is lost.

Test Plan:
- Good PROG: bytes A5 01 20 00 40 00 0F 08 66, then a frame_start pulse.
  - pkt_ok pulses once after 66.
  - prog_buffer stays 0 until frame_start.
  - The cycle after frame_start: prog_buffer=48'h080F00400020, is_sym_mode=1.
- Bad checksum: same PROG with CHK=67.
  - pkt_err pulses once; no pkt_ok.
  - After frame_start, prog_buffer and is_sym_mode are unchanged.
- EXIT after PROG: commit the good PROG, then send A5 02 02 and pulse frame_start.
  - is_sym_mode=0.
  - prog_buffer still 48'h080F00400020.
- Garbage and timeout:
  - Bytes 33 A5 07 → pkt_err after 07 (bad CMD); 33 is ignored.
  - Then A5 01 20 followed by silence for TIMEOUT_CYCLES → pkt_err, busy=0.
  - A following good packet is accepted.
- Boundary race:
  - Final CHK byte arrives in the same cycle as a frame_start pulse → no commit at that frame_start.
  - Commit occurs at the next frame_start.
  - Two good PROG packets before one frame_start → the second payload is committed.
- Async reset: assert rst_pix mid-PAYLOAD, asynchronously to clk_pix.
  - All outputs are 0 immediately.
  - After release, a full good packet is accepted normally.
